shared_bus_mux: RTL

Parametrised, tristate-free replacement for internal shared buses: N_SRC sources, each with its own enable, drive one WIDTH-bit registered output through an AND-OR mux instead of internal `tri` nets. The block arbitrates simultaneous drivers by a selectable mode and detects and counts contention. When no source drives, it acts as a bus keeper, with an optional timed pull-down to zero. It sits between multiple producer blocks and a single registered consumer in the same clock domain.

---
 rtl/shared_bus_mux.sv | 125 ++++++++++++
 1 files changed

// File: rtl/shared_bus_mux.sv
// Tristate-free shared bus: N_SRC enabled sources resolved through an AND-OR mux
// into one registered output, with contention tracking and a keeper / timed pull-down.
module shared_bus_mux #(
    parameter int N_SRC      = 4,
    parameter int WIDTH      = 8,
    parameter int MODE       = 0,
    parameter int CNT_W      = 8,
    parameter int IDLE_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC*WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]         src_en,
    input  logic                     clr_cnt,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [$clog2(N_SRC)-1:0] bus_src,
    output logic                     contention,
    output logic                     contention_sticky,
    output logic [CNT_W-1:0]         contention_cnt,
    output logic                     floating
);
    localparam int SRC_W  = $clog2(N_SRC);
    localparam int IDLE_W = (IDLE_LIMIT < 1) ? 1 : $clog2(IDLE_LIMIT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_LIMIT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_LIMIT > 0) ? IDLE_LIMIT - 1 : 0);

    logic              w_any;
    logic              w_multi;
    logic              w_found;
    logic [SRC_W-1:0]  w_lowest;
    logic [WIDTH-1:0]  w_pri_data;
    logic [WIDTH-1:0]  w_or_data;
    logic [WIDTH-1:0]  w_next_data;

    logic [WIDTH-1:0]  r_bus;
    logic              r_valid;
    logic [SRC_W-1:0]  r_src;
    logic              r_con;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_float;
    logic [IDLE_W-1:0] r_idle;

    assign w_any   = |src_en;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi = |(src_en & (src_en - N_SRC'(1)));

    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_found    = 1'b0;
        w_lowest   = '0;
        w_pri_data = '0;
        w_or_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_en[i]) begin
                w_or_data = w_or_data | src_data[i*WIDTH +: WIDTH];
                if (!w_found) begin
                    w_found    = 1'b1;
                    w_lowest   = SRC_W'(i);
                    w_pri_data = src_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign w_next_data = (MODE == 1) ? w_or_data : w_pri_data;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus    <= '0;
            r_valid  <= 1'b0;
            r_src    <= '0;
            r_con    <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_float  <= 1'b0;
            r_idle   <= '0;
        end else begin
            if (w_any) begin
                r_bus   <= w_next_data;
                r_valid <= 1'b1;
                r_src   <= w_lowest;
                r_idle  <= '0;
                r_float <= 1'b0;
            end else begin
                r_valid <= 1'b0;
                // Keeper: bus and source hold until the idle run reaches the limit.
                if (IDLE_LIMIT != 0 && r_idle != IDLE_MAX) begin
                    r_idle <= r_idle + IDLE_W'(1);
                    if (r_idle == IDLE_LAST) begin
                        r_bus   <= '0;
                        r_float <= 1'b1;
                    end
                end
            end

            r_con <= w_multi;
            // Contention takes precedence over a simultaneous clear.
            if (w_multi) begin
                r_sticky <= 1'b1;
                if (clr_cnt) begin
                    r_cnt <= CNT_W'(1);
                end else if (!(&r_cnt)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (clr_cnt) begin
                r_sticky <= 1'b0;
                r_cnt    <= '0;
            end
        end
    end

    assign bus_out           = r_bus;
    assign bus_valid         = r_valid;
    assign bus_src           = r_src;
    assign contention        = r_con;
    assign contention_sticky = r_sticky;
    assign contention_cnt    = r_cnt;
    assign floating          = r_float;

endmodule
